// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame length, odd-parity rule and
// common keyboard command bytes. Used by the host transmitter and its testbench.
package ps2_host_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_FAIL
  } ps2_state_t;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  function automatic logic ps2_odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the raw PS/2 clock and data lines plus a falling-edge
// strobe on the synchronized clock. Shareable with the PS/2 receive path.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_clock_line,
  input  logic i_data_line,
  output logic o_clock_sync,
  output logic o_data_sync,
  output logic o_clock_fall
);

  logic r_clock_meta;
  logic r_clock_sync;
  logic r_clock_prev;
  logic r_data_meta;
  logic r_data_sync;

  // Lines idle high, so reset to 1 to avoid a phantom edge after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clock_meta <= 1'b1;
      r_clock_sync <= 1'b1;
      r_clock_prev <= 1'b1;
      r_data_meta  <= 1'b1;
      r_data_sync  <= 1'b1;
    end else begin
      r_clock_meta <= i_clock_line;
      r_clock_sync <= r_clock_meta;
      r_clock_prev <= r_clock_sync;
      r_data_meta  <= i_data_line;
      r_data_sync  <= r_data_meta;
    end
  end

  assign o_clock_sync = r_clock_sync;
  assign o_data_sync  = r_data_sync;
  assign o_clock_fall = r_clock_prev & ~r_clock_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out 8 data bits,
// odd parity and stop on device clock falls, then check the device ACK.
// Optional macro PS2_TX_RESEND_EN retries a NACKed or timed-out frame up to MAX_RETRIES times.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRIES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       rx_inhibit,
  output ps2_state_t dbg_state
);

  // Handshake: tx_start is a single-cycle request with tx_data valid in the same
  // cycle; it is taken only when the FSM is idle (busy low, no done/error pulse),
  // otherwise it is dropped. busy is the only back-pressure signal.

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t       r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [7:0]       r_byte, w_byte_next;
  logic             r_parity, w_parity_next;
  logic [3:0]       r_bit_idx, w_bit_idx_next;
  logic             r_data_bit, w_data_bit_next;
  logic             r_ack_bit, w_ack_bit_next;
  logic             w_clock_sync, w_data_sync, w_clock_fall;
  logic             w_fail, w_done;

`ifdef PS2_TX_RESEND_EN
  localparam int RETRY_W = $clog2(MAX_RETRIES + 2);
  logic [RETRY_W-1:0] r_retry, w_retry_next;
`endif

  ps2_line_sync u_sync (
    .clk          (clk),
    .reset        (reset),
    .i_clock_line (ps2_clock_in),
    .i_data_line  (ps2_data_in),
    .o_clock_sync (w_clock_sync),
    .o_data_sync  (w_data_sync),
    .o_clock_fall (w_clock_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_byte     <= '0;
      r_parity   <= 1'b0;
      r_bit_idx  <= '0;
      r_data_bit <= 1'b0;
      r_ack_bit  <= 1'b0;
`ifdef PS2_TX_RESEND_EN
      r_retry    <= '0;
`endif
    end else begin
      r_cnt      <= w_cnt_next;
      r_byte     <= w_byte_next;
      r_parity   <= w_parity_next;
      r_bit_idx  <= w_bit_idx_next;
      r_data_bit <= w_data_bit_next;
      r_ack_bit  <= w_ack_bit_next;
`ifdef PS2_TX_RESEND_EN
      r_retry    <= w_retry_next;
`endif
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_byte_next     = r_byte;
    w_parity_next   = r_parity;
    w_bit_idx_next  = r_bit_idx;
    w_data_bit_next = r_data_bit;
    w_ack_bit_next  = r_ack_bit;
`ifdef PS2_TX_RESEND_EN
    w_retry_next    = r_retry;
`endif
    w_fail       = 1'b0;
    w_done       = 1'b0;
    ps2_clock_oe = 1'b0;
    ps2_data_oe  = 1'b0;
    error        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (tx_start) begin
          w_byte_next   = tx_data;
          w_parity_next = ps2_odd_parity(tx_data);
          w_state_next  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        ps2_clock_oe = 1'b1;
        // Data drops on the last inhibit cycle so it is low before clock is released.
        if (r_cnt == INHIBIT_LAST) begin
          ps2_data_oe  = 1'b1;
          w_cnt_next   = '0;
          w_state_next = ST_REQ;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_REQ, ST_DATA, ST_PARITY, ST_STOP: begin
        ps2_data_oe = (r_state == ST_REQ) ? 1'b1 : r_data_bit;
        if (w_clock_fall) begin
          w_cnt_next = '0;
          case (r_state)
            ST_REQ: begin
              w_data_bit_next = ~r_byte[0];
              w_bit_idx_next  = 4'd1;
              w_state_next    = ST_DATA;
            end
            ST_DATA: begin
              if (r_bit_idx == 4'd8) begin
                w_data_bit_next = ~r_parity;
                w_state_next    = ST_PARITY;
              end else begin
                w_data_bit_next = ~r_byte[r_bit_idx[2:0]];
                w_bit_idx_next  = r_bit_idx + 4'd1;
              end
            end
            ST_PARITY: begin
              w_data_bit_next = 1'b0;
              w_state_next    = ST_STOP;
            end
            default: begin
              w_ack_bit_next = w_data_sync;
              w_state_next   = ST_ACK;
            end
          endcase
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_fail = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_ACK: begin
        if (r_ack_bit) w_fail = 1'b1;
        else           w_state_next = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (w_clock_sync && w_data_sync) begin
          w_done       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_FAIL: begin
        error        = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase

    if (w_fail) begin
      w_cnt_next      = '0;
      w_data_bit_next = 1'b0;
`ifdef PS2_TX_RESEND_EN
      if (r_retry < RETRY_W'(MAX_RETRIES)) begin
        w_retry_next = r_retry + 1'b1;
        w_state_next = ST_INHIBIT;
      end else begin
        w_state_next = ST_FAIL;
      end
`else
      w_state_next = ST_FAIL;
`endif
    end

`ifdef PS2_TX_RESEND_EN
    if (w_done || (r_state == ST_FAIL)) w_retry_next = '0;
`endif

    done = w_done;
    busy = (r_state != ST_IDLE) && (r_state != ST_FAIL) && !w_done;
  end

  assign rx_inhibit = busy;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a simple PS/2 device model clocks frames in,
// returns ACK/NACK or stays silent, and immediate assertions check every step.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH  = 50;
  localparam int TMO  = 1000;
  localparam int RET  = 2;
  localparam int HALF = 20;
`ifdef PS2_TX_RESEND_EN
  localparam int ATTEMPTS = RET + 1;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clock_in, ps2_data_in;
  logic       ps2_clock_oe, ps2_data_oe, busy, done, error, rx_inhibit;
  ps2_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int n_done = 0, n_err = 0, n_busy_bad = 0, n_rx_bad = 0, n_inh = 0;
  logic prev_coe = 1'b0;

  // Open-collector bus: either side pulling low wins.
  assign ps2_clock_in = ~(ps2_clock_oe | dev_clk_low);
  assign ps2_data_in  = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRIES    (RET)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .ps2_clock_in (ps2_clock_in),
    .ps2_data_in  (ps2_data_in),
    .ps2_clock_oe (ps2_clock_oe),
    .ps2_data_oe  (ps2_data_oe),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .rx_inhibit   (rx_inhibit),
    .dbg_state    (dbg_state)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---- pulse monitor ----
  always @(negedge clk) begin
    if (done) n_done++;
    if (error) n_err++;
    if ((done || error) && busy) n_busy_bad++;
    if (rx_inhibit !== busy) n_rx_bad++;
    if (ps2_clock_oe && !prev_coe) n_inh++;
    prev_coe <= ps2_clock_oe;
  end

  // ---- driver tasks ----
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_tx(input logic [7:0] b);
    tx_data  = b;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
  endtask

  task automatic wait_coe(input logic v, input int budget, output logic ok);
    int n = 0;
    while (ps2_clock_oe !== v && n < budget) begin
      tick(1);
      n++;
    end
    ok = (ps2_clock_oe === v);
  endtask

  // inj: 0 none, 1 tx_start 0x55 after bit 3 is read, 2 return mid bit 4 with clock held low
  task automatic dev_frame(input logic ack, input int inj, output logic [PS2_FRAME_BITS-1:0] bits,
                           output int n_low, output int n_doe, output logic start_oe, output logic ok);
    bits = '0; n_low = 0; n_doe = 0; start_oe = 1'b0;
    wait_coe(1'b1, TMO + 100, ok);
    if (!ok) return;
    while (ps2_clock_oe === 1'b1 && n_low < 5 * INH) begin
      n_low++;
      if (ps2_data_oe) n_doe++;
      tick(1);
    end
    start_oe = ps2_data_oe;
    tick(10);
    bits[0] = ps2_data_in;
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      tick(HALF);
      if (inj == 2 && k == 5) return;
      dev_clk_low = 1'b0;
      bits[k] = ps2_data_in;
      if (inj == 1 && k == 4) begin
        tx_data = 8'h55; tx_start = 1'b1; tick(1); tx_start = 1'b0;
      end
      tick(HALF);
    end
    dev_data_low = ack;
    tick(5);
    dev_clk_low = 1'b1;
    tick(HALF);
    dev_clk_low = 1'b0;
    tick(5);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_pulse(input int budget, output int n);
    n = 0;
    while (!(done || error) && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  // Full ACKed transfer; poke = pulse tx_start in the done cycle, which must be ignored.
  task automatic send_ack(input string tag, input logic [7:0] b, input logic [10:0] exp_frame,
                          input logic poke);
    logic [PS2_FRAME_BITS-1:0] bits;
    int n_low, n_doe, n, d0, e0, i0;
    logic s_oe, ok;
    d0 = n_done; e0 = n_err;
    start_tx(b);
    dev_frame(1'b1, 0, bits, n_low, n_doe, s_oe, ok);
    check($sformatf("%s inhibit_seen", tag), ok, 1);
    check($sformatf("%s clock_low_cycles", tag), n_low, INH);
    check($sformatf("%s data_low_in_inhibit", tag), n_doe, 1);
    check($sformatf("%s start_bit_oe", tag), s_oe, 1);
    check($sformatf("%s frame_bits", tag), bits, exp_frame);
    wait_pulse(200, n);
    check($sformatf("%s done_now", tag), done, 1);
    check($sformatf("%s busy_with_done", tag), busy, 0);
    i0 = n_inh;
    if (poke) begin
      tx_data = 8'hAA; tx_start = 1'b1;
    end
    tick(1);
    tx_start = 1'b0;
    check($sformatf("%s idle_after_done", tag), dbg_state, ST_IDLE);
    tick(5);
    check($sformatf("%s done_pulses", tag), n_done - d0, 1);
    check($sformatf("%s error_pulses", tag), n_err - e0, 0);
    check($sformatf("%s no_new_inhibit", tag), n_inh - i0, 0);
    tick(20);
  endtask

  // ---- directed sequence ----
  initial begin
    logic [PS2_FRAME_BITS-1:0] bits;
    int n_low, n_doe, n, d0, e0, i0;
    logic s_oe, ok;

    tick(4);
    check("reset clock_oe", ps2_clock_oe, 0);
    check("reset data_oe", ps2_data_oe, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset error", error, 0);
    check("reset rx_inhibit", rx_inhibit, 0);
    check("reset state", dbg_state, ST_IDLE);
    reset = 1'b0;
    tick(5);

    send_ack("set_leds", PS2_CMD_SET_LEDS, 11'h7DA, 1'b0);
    send_ack("byte_01", 8'h01, 11'h402, 1'b0);
    send_ack("byte_00", 8'h00, 11'h600, 1'b1);

    // Silent device: timeout measured from the last REQ entry.
    d0 = n_done; e0 = n_err; i0 = n_inh;
    start_tx(PS2_CMD_SET_LEDS);
    for (int a = 0; a < ATTEMPTS; a++) begin
      wait_coe(1'b1, TMO + 100, ok);
      check("timeout inhibit_seen", ok, 1);
      wait_coe(1'b0, INH + 10, ok);
      check("timeout req_seen", ok, 1);
    end
    n = 0;
    while (!error && n < TMO + 100) begin
      tick(1);
      n++;
    end
    check("timeout latency", n, TMO);
    check("timeout clock_oe", ps2_clock_oe, 0);
    check("timeout data_oe", ps2_data_oe, 0);
    tick(1);
    check("timeout clock_oe after", ps2_clock_oe, 0);
    check("timeout data_oe after", ps2_data_oe, 0);
    check("timeout busy after", busy, 0);
    check("timeout inhibit_phases", n_inh - i0, ATTEMPTS);
    check("timeout error_pulses", n_err - e0, 1);
    check("timeout done_pulses", n_done - d0, 0);
    tick(20);

    // NACKing device: each attempt carries the same byte.
    d0 = n_done; e0 = n_err;
    start_tx(PS2_CMD_SET_LEDS);
    for (int a = 0; a < ATTEMPTS; a++) begin
      dev_frame(1'b0, 0, bits, n_low, n_doe, s_oe, ok);
      check("nack inhibit_seen", ok, 1);
      check("nack frame_bits", bits, 11'h7DA);
    end
    tick(30);
    check("nack error_pulses", n_err - e0, 1);
    check("nack done_pulses", n_done - d0, 0);
    check("nack busy after", busy, 0);
    tick(20);

    // tx_start during DATA must not disturb the latched byte.
    d0 = n_done; e0 = n_err;
    start_tx(PS2_CMD_RESET);
    dev_frame(1'b1, 1, bits, n_low, n_doe, s_oe, ok);
    check("busy_start inhibit_seen", ok, 1);
    check("busy_start frame_bits", bits, 11'h7FE);
    wait_pulse(200, n);
    tick(20);
    check("busy_start done_pulses", n_done - d0, 1);
    check("busy_start error_pulses", n_err - e0, 0);
    check("busy_start idle", dbg_state, ST_IDLE);

    // Reset while bit 4 is on the wire.
    d0 = n_done; e0 = n_err;
    start_tx(PS2_CMD_SET_LEDS);
    dev_frame(1'b1, 2, bits, n_low, n_doe, s_oe, ok);
    check("midreset inhibit_seen", ok, 1);
    check("midreset in_data", dbg_state, ST_DATA);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midreset clock_oe", ps2_clock_oe, 0);
    check("midreset data_oe", ps2_data_oe, 0);
    check("midreset busy", busy, 0);
    dev_clk_low = 1'b0;
    tick(30);
    check("midreset done_pulses", n_done - d0, 0);
    check("midreset error_pulses", n_err - e0, 0);
    send_ack("after_reset", PS2_CMD_SET_LEDS, 11'h7DA, 1'b0);

    check("busy_during_pulse cycles", n_busy_bad, 0);
    check("rx_inhibit_vs_busy cycles", n_rx_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
